// File: rtl/dilation_frame_packer.sv
// dilation_frame_packer
//
// Packs a stream of 8-bit dilated pixels into 32-bit little-endian words and
// writes them into one bank of a double-buffered frame buffer. When a full
// IMG_WIDTH x IMG_HEIGHT frame has been written, the bank flips so the host
// can read the finished frame from ~wb_bank while the next frame fills.
//
// Handshake: dilation_valid is a one-cycle strobe with no backpressure. A
// pixel is accepted on any rising edge where sensor_state=1, dilation_valid=1
// and the FSM is ARMED or CAPTURE. The block never stalls the source.
//
// Ports
//   s_axi_aclk     sole clock
//   s_axi_aresetn  asynchronous active-low reset
//   sensor_state   capture enable (1 = sensor streaming)
//   dilation_valid pixel strobe
//   dilation_dout  pixel value
//   wb_wren        one-cycle write strobe, one cycle after a word's 4th pixel
//   wb_addr        word address within the bank (valid with wb_wren)
//   wb_wrdata      packed pixels, pixel 4k+0 in [7:0]
//   wb_bank        bank being written; host reads ~wb_bank
//   frame_done     pulse coincident with the final write of a frame
//   frame_abort    pulse when a partial frame is discarded
//   frame_count    (only with DILATION_FRAME_CNT_EN) completed-frame counter
//
// Optional feature macro: DILATION_FRAME_CNT_EN adds frame_count.
//
// Note: wb_addr is 16 bits, which covers frames up to 262144 pixels
// (e.g. the 512x512 default).

module dilation_frame_packer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        sensor_state,
    input  logic        dilation_valid,
    input  logic [7:0]  dilation_dout,
    output logic        wb_wren,
    output logic [15:0] wb_addr,
    output logic [31:0] wb_wrdata,
    output logic        wb_bank,
    output logic        frame_done,
    output logic        frame_abort
`ifdef DILATION_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [15:0]      LAST_WORD = 16'((IMG_WIDTH * IMG_HEIGHT) / 4 - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    logic [1:0]       state_q,       state_d;
    logic [COL_W-1:0] col_q,         col_d;
    logic [ROW_W-1:0] row_q,         row_d;
    logic [23:0]      pack_q,        pack_d;
    logic             wb_wren_q,     wb_wren_d;
    logic [15:0]      wb_addr_q,     wb_addr_d;
    logic [31:0]      wb_wrdata_q,   wb_wrdata_d;
    logic             wb_bank_q,     wb_bank_d;
    logic             frame_done_q,  frame_done_d;
    logic             frame_abort_q, frame_abort_d;

    logic accept;
    logic last_pix;

    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign accept   = sensor_state && dilation_valid &&
                      ((state_q == ST_ARMED) || (state_q == ST_CAPTURE));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        pack_d        = pack_q;
        wb_wren_d     = 1'b0;
        wb_addr_d     = wb_addr_q;
        wb_wrdata_d   = wb_wrdata_q;
        wb_bank_d     = wb_bank_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;

        // Bank flips the cycle after the final write of a frame.
        if (frame_done_q) begin
            wb_bank_d = ~wb_bank_q;
        end

        // Address advances once the current word has been presented, so
        // wb_addr still equals k during the write of word k.
        if (wb_wren_q) begin
            wb_addr_d = (wb_addr_q == LAST_WORD) ? 16'd0 : wb_addr_q + 16'd1;
        end

        if (!sensor_state) begin
            // Sensor stop wins over everything, including a final pixel in
            // this same cycle: the partial frame is dropped, bank untouched.
            state_d       = ST_IDLE;
            col_d         = '0;
            row_d         = '0;
            pack_d        = '0;
            wb_addr_d     = '0;
            frame_abort_d = (state_q == ST_CAPTURE);
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARMED;
                ST_ARMED:   if (dilation_valid) state_d = ST_CAPTURE;
                ST_CAPTURE: if (dilation_valid && last_pix) state_d = ST_ARMED;
                default:    state_d = ST_IDLE;
            endcase

            if (accept) begin
                // IMG_WIDTH is a multiple of 4, so the low column bits give
                // the byte lane directly.
                case (col_q[1:0])
                    2'd0: pack_d[7:0]   = dilation_dout;
                    2'd1: pack_d[15:8]  = dilation_dout;
                    2'd2: pack_d[23:16] = dilation_dout;
                    2'd3: begin
                        wb_wren_d   = 1'b1;
                        wb_wrdata_d = {dilation_dout, pack_q};
                        pack_d      = '0;
                    end
                endcase

                if (last_pix) begin
                    col_d        = '0;
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            pack_q        <= '0;
            wb_wren_q     <= 1'b0;
            wb_addr_q     <= '0;
            wb_wrdata_q   <= '0;
            wb_bank_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pack_q        <= pack_d;
            wb_wren_q     <= wb_wren_d;
            wb_addr_q     <= wb_addr_d;
            wb_wrdata_q   <= wb_wrdata_d;
            wb_bank_q     <= wb_bank_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign wb_wren     = wb_wren_q;
    assign wb_addr     = wb_addr_q;
    assign wb_wrdata   = wb_wrdata_q;
    assign wb_bank     = wb_bank_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

`ifdef DILATION_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Counts completed frames only; wraps naturally at 16 bits.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_done_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_dilation_frame_packer.sv
// Directed testbench for dilation_frame_packer at IMG_WIDTH=8, IMG_HEIGHT=2
// (16 pixels, 4 words per frame).

module tb_dilation_frame_packer;

    localparam int W = 8;
    localparam int H = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sensor = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  dout = 8'd0;
    logic        wb_wren;
    logic [15:0] wb_addr;
    logic [31:0] wb_wrdata;
    logic        wb_bank;
    logic        frame_done;
    logic        frame_abort;
`ifdef DILATION_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    dilation_frame_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rstn),
        .sensor_state   (sensor),
        .dilation_valid (valid),
        .dilation_dout  (dout),
        .wb_wren        (wb_wren),
        .wb_addr        (wb_addr),
        .wb_wrdata      (wb_wrdata),
        .wb_bank        (wb_bank),
        .frame_done     (frame_done),
`ifdef DILATION_FRAME_CNT_EN
        .frame_count    (frame_count),
`endif
        .frame_abort    (frame_abort)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_bad = 0;
    logic [48:0] exp_q[$];
    logic [48:0] wr_q[$];
    int          n_done;
    int          n_abort;
    logic        done_wren;
    logic [15:0] done_addr;
    logic        bank_at_done;
    logic        bank_after_done;
    logic        done_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (wb_wren) wr_q.push_back({wb_bank, wb_addr, wb_wrdata});
            if (done_prev) bank_after_done = wb_bank;
            if (frame_done) begin
                n_done++;
                done_wren    = wb_wren;
                done_addr    = wb_addr;
                bank_at_done = wb_bank;
            end
            if (frame_abort) n_abort++;
            done_prev = frame_done;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        wr_q.delete();
        n_done = 0;
        n_abort = 0;
        done_wren = 1'b0;
        done_addr = 16'hffff;
        bank_at_done = 1'bx;
        bank_after_done = 1'bx;
        done_prev = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    // Expected packed word k of a run of pixels base, base+1, ...
    function automatic logic [31:0] word_of(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(4 * k);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic push_frame(input logic bank, input logic [7:0] base, input int words);
        for (int k = 0; k < words; k++) exp_q.push_back({bank, 16'(k), word_of(base, k)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        sensor = s;
        valid  = v;
        dout   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input int n, input logic [7:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, base + 8'(i));
            for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        sensor = 1'b0;
        valid  = 1'b0;
        dout   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_sb();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"},  64'(wb_wren),     64'd0);
        check({tag, "_addr"},  64'(wb_addr),     64'd0);
        check({tag, "_data"},  64'(wb_wrdata),   64'd0);
        check({tag, "_bank"},  64'(wb_bank),     64'd0);
        check({tag, "_done"},  64'(frame_done),  64'd0);
        check({tag, "_abort"}, 64'(frame_abort), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_sb();

        // Reset state
        do_reset();
        check_outputs_zero("rst");

        // Single word: arm, then 01..04 back to back
        step(1'b1, 1'b0, 8'h00);
        send_pixels(3, 8'h01, 0);
        check("w1_no_early_wren", 64'(wb_wren), 64'd0);
        step(1'b1, 1'b1, 8'h04);
        check("w1_wren", 64'(wb_wren),   64'd1);
        check("w1_addr", 64'(wb_addr),   64'd0);
        check("w1_data", 64'(wb_wrdata), 64'h04030201);
        step(1'b1, 1'b0, 8'h00);
        check("w1_wren_pulse", 64'(wb_wren), 64'd0);

        // Full frame with gapped valid
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        send_pixels(16, 8'h10, 1);
        step(1'b1, 1'b0, 8'h00);
        push_frame(1'b0, 8'h10, 4);
        compare_writes("ff");
        check("ff_done_cnt",   64'(n_done),          64'd1);
        check("ff_done_wren",  64'(done_wren),       64'd1);
        check("ff_done_addr",  64'(done_addr),       64'd3);
        check("ff_bank_at",    64'(bank_at_done),    64'd0);
        check("ff_bank_after", 64'(bank_after_done), 64'd1);
        check("ff_addr_wrap",  64'(wb_addr),         64'd0);
        check("ff_abort_cnt",  64'(n_abort),         64'd0);

        // Abort after 6 pixels, then a fresh word starts at addr 0
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        send_pixels(6, 8'h31, 0);
        step(1'b0, 1'b0, 8'h00);
        check("ab_abort_pulse", 64'(frame_abort), 64'd1);
        step(1'b0, 1'b0, 8'h00);
        check("ab_abort_one", 64'(frame_abort), 64'd0);
        check("ab_addr_clr",  64'(wb_addr),     64'd0);
        exp_q.push_back({1'b0, 16'd0, 32'h34333231});
        step(1'b1, 1'b0, 8'h00);
        send_pixels(4, 8'h41, 0);
        step(1'b1, 1'b0, 8'h00);
        exp_q.push_back({1'b0, 16'd0, 32'h44434241});
        compare_writes("ab");
        check("ab_abort_cnt", 64'(n_abort), 64'd1);
        check("ab_done_cnt",  64'(n_done),  64'd0);
        check("ab_bank",      64'(wb_bank), 64'd0);

        // Sensor falls together with the final pixel: abort wins
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        send_pixels(15, 8'h50, 0);
        step(1'b0, 1'b1, 8'h5f);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        push_frame(1'b0, 8'h50, 3);
        compare_writes("lp");
        check("lp_done_cnt",  64'(n_done),  64'd0);
        check("lp_abort_cnt", 64'(n_abort), 64'd1);
        check("lp_bank",      64'(wb_bank), 64'd0);

        // Two frames back to back, continuous valid
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        send_pixels(16, 8'h20, 0);
        send_pixels(16, 8'h60, 0);
        repeat (2) step(1'b1, 1'b0, 8'h00);
        push_frame(1'b0, 8'h20, 4);
        push_frame(1'b1, 8'h60, 4);
        compare_writes("bb");
        check("bb_done_cnt", 64'(n_done),  64'd2);
        check("bb_bank_end", 64'(wb_bank), 64'd0);

        // Reset mid-word: continue from the previous frame, 3 pixels in
        send_pixels(3, 8'h71, 0);
        rstn = 1'b0;
        #1;
        check_outputs_zero("mr_async");
        @(posedge clk);
        #1;
        check_outputs_zero("mr_held");
        rstn = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        check_outputs_zero("mr_after");
        send_pixels(4, 8'h81, 0);
        step(1'b1, 1'b0, 8'h00);
        exp_q.push_back({1'b0, 16'd0, 32'h84838281});
        compare_writes("mr");

`ifdef DILATION_FRAME_CNT_EN
        // Three complete frames plus one aborted frame
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        for (int f = 0; f < 3; f++) send_pixels(16, 8'h00, 0);
        send_pixels(5, 8'h90, 0);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check("fc_count", 64'(frame_count), 64'd3);
        check("fc_bank",  64'(wb_bank),     64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
